// File: rtl/counter36_capture_fifo.sv
// Captures a free-running counter into a first-word-fall-through FIFO together with
// the modular delta since the previous accepted capture; a sticky flag marks dropped captures.
module counter36_capture_fifo #(
   parameter int unsigned N     = 36,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N-1:0]             count_in,
   input  logic                     capture,
   output logic [N-1:0]             out_count,
   output logic [N-1:0]             out_delta,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clear_ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   LvlFull = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   LvlOne  = (AW + 1)'(1);
   localparam logic [AW-1:0] PtrOne  = AW'(1);

   logic [N-1:0]  cnt_mem_q [DEPTH];
   logic [N-1:0]  cnt_mem_d [DEPTH];
   logic [N-1:0]  dlt_mem_q [DEPTH];
   logic [N-1:0]  dlt_mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [N-1:0]  last_cap_q, last_cap_d;
   logic          ovf_q, ovf_d;
   logic          push, pop;

   always_comb begin
      pop        = (level_q != '0) && out_ready;
      // A pop at the same edge frees the slot the push needs when full.
      push       = capture && ((level_q != LvlFull) || pop);
      cnt_mem_d  = cnt_mem_q;
      dlt_mem_d  = dlt_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      last_cap_d = last_cap_q;
      level_d    = level_q;
      ovf_d      = ovf_q;

      if (push) begin
         cnt_mem_d[wr_ptr_q] = count_in;
         dlt_mem_d[wr_ptr_q] = count_in - last_cap_q;
         wr_ptr_d            = wr_ptr_q + PtrOne;
         last_cap_d          = count_in;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + LvlOne;
         2'b01:   level_d = level_q - LvlOne;
         default: level_d = level_q;
      endcase

      if (clear_ovf) begin
         ovf_d = 1'b0;
      end
      if (capture && !push) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            cnt_mem_q[i] <= '0;
            dlt_mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         last_cap_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         cnt_mem_q  <= cnt_mem_d;
         dlt_mem_q  <= dlt_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         last_cap_q <= last_cap_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_count = cnt_mem_q[rd_ptr_q];
   assign out_delta = dlt_mem_q[rd_ptr_q];
   assign out_valid = (level_q != '0);
   assign level     = level_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_counter36_capture_fifo.sv
// Directed bench for counter36_capture_fifo: a queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_counter36_capture_fifo;

   localparam int N     = 36;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic [N-1:0]  count_in;
   logic          capture;
   logic [N-1:0]  out_count;
   logic [N-1:0]  out_delta;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    level;
   logic          overflow;
   logic          clear_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   counter36_capture_fifo #(.N(N), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .count_in  (count_in),
      .capture   (capture),
      .out_count (out_count),
      .out_delta (out_delta),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .clear_ovf (clear_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: entries are {count, delta}
   logic [2*N-1:0] m_q[$];
   logic [N-1:0]   m_last = '0;
   logic           m_ovf  = 1'b0;

   always @(negedge reset) begin
      m_q.delete();
      m_last = '0;
      m_ovf  = 1'b0;
   end

   always @(posedge clk) begin
      if (reset) begin
         bit m_pop, m_push;
         m_pop  = (m_q.size() != 0) && out_ready;
         m_push = capture && ((m_q.size() < DEPTH) || m_pop);
         if (m_pop) void'(m_q.pop_front());
         if (m_push) begin
            m_q.push_back({count_in, count_in - m_last});
            m_last = count_in;
         end
         if (clear_ovf) m_ovf = 1'b0;
         if (capture && !m_push) m_ovf = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("model_valid", 64'(out_valid), 64'(m_q.size() != 0));
         chk("model_level", 64'(level), 64'(m_q.size()));
         chk("model_ovf", 64'(overflow), 64'(m_ovf));
         if (m_q.size() != 0) begin
            chk("model_count", 64'(out_count), 64'(m_q[0][2*N-1:N]));
            chk("model_delta", 64'(out_delta), 64'(m_q[0][N-1:0]));
         end
      end
   end

   task automatic step(input logic c, input logic [N-1:0] v, input logic r, input logic cl);
      capture   = c;
      count_in  = v;
      out_ready = r;
      clear_ovf = cl;
      @(posedge clk);
      @(negedge clk);
      capture   = 1'b0;
      out_ready = 1'b0;
      clear_ovf = 1'b0;
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_count", 64'(out_count), 64'd0);
      chk("rst_delta", 64'(out_delta), 64'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   logic [N-1:0] exp_c [4];
   logic [N-1:0] exp_d [4];

   initial begin
      reset     = 1'b0;
      count_in  = '0;
      capture   = 1'b0;
      out_ready = 1'b0;
      clear_ovf = 1'b0;
      #1;
      chk("init_valid", 64'(out_valid), 64'd0);
      chk("init_level", 64'(level), 64'd0);
      chk("init_ovf", 64'(overflow), 64'd0);
      chk("init_count", 64'(out_count), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // First capture right after release, fall-through on the next cycle
      step(1'b1, 36'h000000010, 1'b0, 1'b0);
      chk("first_valid", 64'(out_valid), 64'd1);
      chk("first_count", 64'(out_count), 64'h10);
      chk("first_delta", 64'(out_delta), 64'h10);
      chk("first_level", 64'(level), 64'd1);
      step(1'b0, '0, 1'b1, 1'b0);
      // Empty with ready and no capture: nothing moves
      step(1'b0, '0, 1'b1, 1'b0);
      chk("empty_level", 64'(level), 64'd0);

      pulse_reset();

      // Fill to full, fifth capture dropped
      step(1'b1, 36'd5, 1'b0, 1'b0);
      step(1'b1, 36'd9, 1'b0, 1'b0);
      step(1'b1, 36'd20, 1'b0, 1'b0);
      step(1'b1, 36'd21, 1'b0, 1'b0);
      step(1'b1, 36'd30, 1'b0, 1'b0);
      chk("full_level", 64'(level), 64'd4);
      chk("drop_ovf", 64'(overflow), 64'd1);
      exp_c = '{36'd5, 36'd9, 36'd20, 36'd21};
      exp_d = '{36'd5, 36'd4, 36'd11, 36'd1};
      for (int i = 0; i < 4; i++) begin
         chk("drain_count", 64'(out_count), 64'(exp_c[i]));
         chk("drain_delta", 64'(out_delta), 64'(exp_d[i]));
         step(1'b0, '0, 1'b1, 1'b0);
      end
      chk("drained_level", 64'(level), 64'd0);
      chk("ovf_sticky", 64'(overflow), 64'd1);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("ovf_cleared", 64'(overflow), 64'd0);

      // Full with a simultaneous pop: accepted, lands last
      step(1'b1, 36'd100, 1'b0, 1'b0);
      step(1'b1, 36'd110, 1'b0, 1'b0);
      step(1'b1, 36'd120, 1'b0, 1'b0);
      step(1'b1, 36'd130, 1'b0, 1'b0);
      chk("hold_count", 64'(out_count), 64'd100);
      chk("hold_delta", 64'(out_delta), 64'd79);
      step(1'b1, 36'd140, 1'b1, 1'b0);
      chk("pushpop_level", 64'(level), 64'd4);
      chk("pushpop_ovf", 64'(overflow), 64'd0);
      exp_c = '{36'd110, 36'd120, 36'd130, 36'd140};
      for (int i = 0; i < 4; i++) begin
         chk("pp_drain_count", 64'(out_count), 64'(exp_c[i]));
         chk("pp_drain_delta", 64'(out_delta), 64'd10);
         step(1'b0, '0, 1'b1, 1'b0);
      end

      // Modular delta across wrap
      step(1'b1, 36'hFFFFFFFFE, 1'b1, 1'b0);
      step(1'b1, 36'h000000001, 1'b1, 1'b0);
      chk("wrap_count", 64'(out_count), 64'h1);
      chk("wrap_delta", 64'(out_delta), 64'h3);
      step(1'b0, '0, 1'b1, 1'b0);

      // Drop and clear at the same edge: set wins
      for (int i = 0; i < 4; i++) step(1'b1, 36'(i + 2), 1'b0, 1'b0);
      step(1'b1, 36'd6, 1'b0, 1'b1);
      chk("setwins_ovf", 64'(overflow), 64'd1);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("clear_ovf", 64'(overflow), 64'd0);

      // Asynchronous reset with three entries stored
      step(1'b0, '0, 1'b1, 1'b0);
      chk("three_level", 64'(level), 64'd3);
      pulse_reset();
      step(1'b1, 36'd7, 1'b0, 1'b0);
      chk("post_rst_count", 64'(out_count), 64'd7);
      chk("post_rst_delta", 64'(out_delta), 64'd7);

      // Mixed traffic checked against the model
      for (int i = 0; i < 24; i++) begin
         step((i % 3) != 0, 36'h1000 + 36'(i * 7), (i % 2 == 1) || (i % 5 == 0), (i % 8) == 7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
